// File: rtl/trace_port_tx_pkg.sv
// Shared types, TPIU constants and width helpers for the trace port transmitter.
package trace_port_tx_pkg;

  typedef enum logic [1:0] {
    SYNC,
    DATA,
    IDLE_INV
  } state_e;

  localparam logic [31:0] TPIU_SYNC = 32'h7fff_ffff;
  localparam logic [15:0] TPIU_FILL = 16'h7fff;

  function automatic logic width_valid(input logic [2:0] w);
    return (w == 3'd1) || (w == 3'd2) || (w == 3'd4);
  endfunction

  // Cycles needed to drive one unit: each cycle carries 2*w bits.
  function automatic logic [4:0] slices_per_unit(input logic [2:0] w, input logic is_sync);
    logic [4:0] n;
    case (w)
      3'd1:    n = 5'd8;
      3'd2:    n = 5'd4;
      3'd4:    n = 5'd2;
      default: n = 5'd0;
    endcase
    return is_sync ? {n[3:0], 1'b0} : n;
  endfunction

endpackage

// File: rtl/trace_port_tx_shifter.sv
// Unit shift register: latches width and unit on load cycles, then emits
// LSB-first rising/falling slices of the latched width each clock.
module trace_port_tx_shifter
  import trace_port_tx_pkg::*;
#(
  parameter int BUSWIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  input  logic                load_is_sync,
  input  logic [31:0]         load_data,
  input  logic [2:0]          load_width,
  output logic                load_cycle,
  output logic [2:0]          cur_width,
  output logic [BUSWIDTH-1:0] dout_a,
  output logic [BUSWIDTH-1:0] dout_b
);

  logic [31:0]         shift_q, shift_d, unit;
  logic [2:0]          width_q, width_d;
  logic [4:0]          remaining_q, remaining_d;
  logic [BUSWIDTH-1:0] a_q, a_d, b_q, b_d;

  assign load_cycle = (remaining_q == 5'd0);
  assign cur_width  = width_q;
  assign dout_a     = a_q;
  assign dout_b     = b_q;

  // The first slice of a freshly loaded unit goes out on the same edge as the load.
  always_comb begin
    unit        = shift_q;
    width_d     = width_q;
    remaining_d = remaining_q - 5'd1;
    shift_d     = shift_q;
    a_d         = '0;
    b_d         = '0;
    if (load_cycle) begin
      width_d     = load_width;
      unit        = load_valid ? load_data : 32'd0;
      remaining_d = load_valid ? (slices_per_unit(load_width, load_is_sync) - 5'd1) : 5'd0;
    end
    case (width_d)
      3'd1: begin
        a_d[0]   = unit[0];
        b_d[0]   = unit[1];
        shift_d  = unit >> 2;
      end
      3'd2: begin
        a_d[1:0] = unit[1:0];
        b_d[1:0] = unit[3:2];
        shift_d  = unit >> 4;
      end
      3'd4: begin
        a_d[3:0] = unit[3:0];
        b_d[3:0] = unit[7:4];
        shift_d  = unit >> 8;
      end
      default: shift_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q     <= 32'd0;
      width_q     <= 3'd0;
      remaining_q <= 5'd0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      shift_q     <= shift_d;
      width_q     <= width_d;
      remaining_q <= remaining_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

endmodule

// File: rtl/trace_port_tx.sv
// Trace port transmitter top: handshake, sync/data/fill priority and sync interval.
// Optional TRACE_PORT_TX_SYNC_REQ_EN adds a sticky syncReq input.
module trace_port_tx
  import trace_port_tx_pkg::*;
#(
  parameter int BUSWIDTH      = 4,
  parameter int SYNC_INTERVAL = 4096
) (
  input  logic                clk,
  input  logic                rst,
`ifdef TRACE_PORT_TX_SYNC_REQ_EN
  input  logic                syncReq,
`endif
  input  logic [2:0]          width,
  input  logic [15:0]         WdIn,
  input  logic                WdValid,
  output logic                WdReady,
  output logic [BUSWIDTH-1:0] traceDouta,
  output logic [BUSWIDTH-1:0] traceDoutb,
  output logic                syncTx
);

  localparam logic [15:0] INTERVAL = 16'(SYNC_INTERVAL);

  state_e      state_q, state_d;
  logic        sync_pend_q, sync_pend_d;
  logic [15:0] interval_q, interval_d;
  logic        req_pend;
  logic        load_cycle, w_ok, sync_due;
  logic [2:0]  cur_width;
  logic [31:0] load_data;

  assign w_ok     = width_valid(width);
  assign sync_due = sync_pend_q || req_pend || (width != cur_width) ||
                    (state_q == IDLE_INV) || (interval_q >= INTERVAL);
  assign WdReady  = !rst && load_cycle && w_ok && !sync_due;
  assign syncTx   = !rst && load_cycle && w_ok && sync_due;

`ifdef TRACE_PORT_TX_SYNC_REQ_EN
  logic req_q, req_d;

  // A request seen while a sync is being loaded is folded into that sync.
  always_comb begin
    req_d = req_q | syncReq;
    if (load_cycle && w_ok && sync_due) req_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) req_q <= 1'b0;
    else     req_q <= req_d;
  end

  assign req_pend = req_q;
`else
  assign req_pend = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sync_pend_d = sync_pend_q;
    interval_d  = interval_q;
    load_data   = {16'h0000, TPIU_FILL};
    if (load_cycle) begin
      if (!w_ok) begin
        state_d     = IDLE_INV;
        interval_d  = 16'd0;
        sync_pend_d = 1'b1;
        load_data   = 32'd0;
      end else if (sync_due) begin
        state_d     = SYNC;
        interval_d  = 16'd0;
        sync_pend_d = 1'b0;
        load_data   = TPIU_SYNC;
      end else begin
        state_d     = DATA;
        interval_d  = interval_q + 16'd1;
        load_data   = {16'h0000, WdValid ? WdIn : TPIU_FILL};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      sync_pend_q <= 1'b1;
      interval_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      sync_pend_q <= sync_pend_d;
      interval_q  <= interval_d;
    end
  end

  trace_port_tx_shifter #(
    .BUSWIDTH(BUSWIDTH)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (w_ok),
    .load_is_sync(sync_due),
    .load_data   (load_data),
    .load_width  (width),
    .load_cycle  (load_cycle),
    .cur_width   (cur_width),
    .dout_a      (traceDouta),
    .dout_b      (traceDoutb)
  );

endmodule

// File: tb/tb_trace_port_tx.sv
// Self-checking bench for trace_port_tx: vector table, directed corner sequences
// and randomized traffic against a bit-queue reference model.
module tb_trace_port_tx;

  localparam int BW       = 4;
  localparam int INTERVAL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    width = 3'd4;
  logic [15:0]   wdIn = 16'h0;
  logic          wdValid = 1'b0;
  logic          WdReady, syncTx;
  logic [BW-1:0] traceDouta, traceDoutb;

  int testCount = 0;
  int failCount = 0;

  // Reference model: pending bits of the current unit, LSB first.
  logic modelBits[$];
  int   mLw = 0;
  bit   mPend = 1'b1;
  bit   mInv = 1'b0;
  int   mCnt = 0;
  bit   lastRdy, lastSync;

  typedef struct {
    logic [2:0]  w;
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        sync;
    logic [3:0]  a;
    logic [3:0]  b;
  } vec_t;

  vec_t vecs[13];
  logic [1:0] w1Pairs[8];

  trace_port_tx #(
    .BUSWIDTH(BW),
    .SYNC_INTERVAL(INTERVAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .width     (width),
    .WdIn      (wdIn),
    .WdValid   (wdValid),
    .WdReady   (WdReady),
    .traceDouta(traceDouta),
    .traceDoutb(traceDoutb),
    .syncTx    (syncTx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] w, input logic v, input logic [15:0] d);
    rst     = r;
    width   = w;
    wdValid = v;
    wdIn    = d;
  endtask

  task automatic pushUnit(input logic [31:0] u, input int n);
    for (int i = 0; i < n; i++) modelBits.push_back(u[i]);
  endtask

  // One clock: predict and check handshake before the edge, outputs after it.
  task automatic step();
    bit            expRdy, expSync, due;
    logic [BW-1:0] ea, eb;
    @(negedge clk);
    expRdy  = 1'b0;
    expSync = 1'b0;
    if (rst) begin
      modelBits.delete();
      mLw = 0; mPend = 1'b1; mInv = 1'b0; mCnt = 0;
    end else if (modelBits.size() == 0) begin
      if (!(width == 3'd1 || width == 3'd2 || width == 3'd4)) begin
        mInv = 1'b1; mCnt = 0; mPend = 1'b1; mLw = int'(width);
      end else begin
        due  = mPend || mInv || (int'(width) != mLw) || (mCnt >= INTERVAL);
        mLw  = int'(width);
        mInv = 1'b0;
        if (due) begin
          expSync = 1'b1; mPend = 1'b0; mCnt = 0;
          pushUnit(32'h7fff_ffff, 32);
        end else begin
          expRdy = 1'b1; mCnt++;
          pushUnit({16'h0000, wdValid ? wdIn : 16'h7fff}, 16);
        end
      end
    end
    lastRdy  = WdReady;
    lastSync = syncTx;
    checkOutput("model WdReady", 32'(WdReady), 32'(expRdy));
    checkOutput("model syncTx", 32'(syncTx), 32'(expSync));
    ea = '0;
    eb = '0;
    if (!rst) begin
      for (int i = 0; i < mLw && i < BW; i++)
        if (modelBits.size() > 0) ea[i] = modelBits.pop_front();
      for (int i = 0; i < mLw && i < BW; i++)
        if (modelBits.size() > 0) eb[i] = modelBits.pop_front();
    end
    @(posedge clk);
    #1;
    checkOutput("model traceDouta", 32'(traceDouta), 32'(ea));
    checkOutput("model traceDoutb", 32'(traceDoutb), 32'(eb));
  endtask

  task automatic doReset(input logic [2:0] w);
    applyStimulus(1'b1, w, 1'b0, 16'h0);
    step();
    step();
    checkOutput("reset traceDouta", 32'(traceDouta), 32'd0);
    checkOutput("reset traceDoutb", 32'(traceDoutb), 32'd0);
    checkOutput("reset WdReady", 32'(lastRdy), 32'd0);
    checkOutput("reset syncTx", 32'(lastSync), 32'd0);
  endtask

  initial begin
    int n, syncCnt, rdyCnt, noisy;

    vecs[0]  = '{3'd4, 1'b1, 16'h1234, 1'b0, 1'b1, 4'hf, 4'hf};
    vecs[1]  = '{3'd4, 1'b1, 16'h1234, 1'b0, 1'b0, 4'hf, 4'hf};
    vecs[2]  = '{3'd4, 1'b1, 16'h1234, 1'b0, 1'b0, 4'hf, 4'hf};
    vecs[3]  = '{3'd4, 1'b1, 16'h1234, 1'b0, 1'b0, 4'hf, 4'h7};
    vecs[4]  = '{3'd4, 1'b1, 16'h1234, 1'b1, 1'b0, 4'h4, 4'h3};
    vecs[5]  = '{3'd4, 1'b1, 16'h5678, 1'b0, 1'b0, 4'h2, 4'h1};
    vecs[6]  = '{3'd4, 1'b1, 16'h5678, 1'b1, 1'b0, 4'h8, 4'h7};
    vecs[7]  = '{3'd4, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h6, 4'h5};
    vecs[8]  = '{3'd4, 1'b0, 16'h0000, 1'b1, 1'b0, 4'hf, 4'hf};
    vecs[9]  = '{3'd4, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hf, 4'h7};
    vecs[10] = '{3'd4, 1'b0, 16'h0000, 1'b1, 1'b0, 4'hf, 4'hf};
    vecs[11] = '{3'd4, 1'b0, 16'h0000, 1'b0, 1'b0, 4'hf, 4'h7};
    vecs[12] = '{3'd4, 1'b0, 16'h0000, 1'b0, 1'b1, 4'hf, 4'hf};
    w1Pairs  = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};

    // Startup sync, two streamed words, fill, then the interval sync after 4 units.
    doReset(3'd4);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b0, vecs[i].w, vecs[i].v, vecs[i].d);
      step();
      checkOutput($sformatf("vec%0d WdReady", i), 32'(lastRdy), 32'(vecs[i].rdy));
      checkOutput($sformatf("vec%0d syncTx", i), 32'(lastSync), 32'(vecs[i].sync));
      checkOutput($sformatf("vec%0d traceDouta", i), 32'(traceDouta), 32'(vecs[i].a));
      checkOutput($sformatf("vec%0d traceDoutb", i), 32'(traceDoutb), 32'(vecs[i].b));
    end

    // Width 1: 16-cycle sync, then 0xA5A5 over 8 cycles.
    doReset(3'd1);
    applyStimulus(1'b0, 3'd1, 1'b1, 16'hA5A5);
    n = 0;
    step();
    while (!lastRdy && n < 40) begin
      n++;
      step();
    end
    checkOutput("w1 sync length", 32'(n), 32'd16);
    applyStimulus(1'b0, 3'd1, 1'b0, 16'h0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      checkOutput($sformatf("w1 pair%0d", k), 32'({traceDouta[0], traceDoutb[0]}), 32'(w1Pairs[k]));
      checkOutput($sformatf("w1 upper%0d", k), 32'({traceDouta[BW-1:1], traceDoutb[BW-1:1]}), 32'd0);
    end

    // Width change 4->2 in the middle of a halfword.
    doReset(3'd4);
    applyStimulus(1'b0, 3'd4, 1'b1, 16'hBEEF);
    n = 0;
    step();
    while (!lastRdy && n < 40) begin
      n++;
      step();
    end
    checkOutput("wc accept cycle", 32'(n), 32'd4);
    checkOutput("wc first slice", 32'({traceDouta, traceDoutb}), 32'h000000FE);
    applyStimulus(1'b0, 3'd2, 1'b1, 16'hCAFE);
    step();
    checkOutput("wc finish ready", 32'(lastRdy), 32'd0);
    checkOutput("wc finish slice", 32'({traceDouta, traceDoutb}), 32'h000000EB);
    syncCnt = 0;
    rdyCnt  = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) checkOutput("wc sync first", 32'(lastSync), 32'd1);
      syncCnt += int'(lastSync);
      rdyCnt  += int'(lastRdy);
    end
    checkOutput("wc sync count", 32'(syncCnt), 32'd1);
    checkOutput("wc ready during sync", 32'(rdyCnt), 32'd0);
    step();
    checkOutput("wc data ready", 32'(lastRdy), 32'd1);
    checkOutput("wc data slice", 32'({traceDouta, traceDoutb}), 32'h00000023);

    // Invalid width holds the bus quiet; returning to 2 starts with sync.
    doReset(3'd3);
    applyStimulus(1'b0, 3'd3, 1'b1, 16'h1357);
    noisy = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (traceDouta != '0 || traceDoutb != '0 || lastRdy || lastSync) noisy++;
    end
    checkOutput("inv quiet", 32'(noisy), 32'd0);
    applyStimulus(1'b0, 3'd2, 1'b1, 16'h1357);
    step();
    checkOutput("inv exit sync", 32'(lastSync), 32'd1);
    n = 1;
    step();
    while (!lastRdy && n < 30) begin
      n++;
      step();
    end
    checkOutput("inv exit data cycle", 32'(n), 32'd8);

    // Randomized traffic, widths and occasional resets against the model.
    doReset(3'd4);
    applyStimulus(1'b0, 3'd4, 1'b0, 16'h0);
    for (int k = 0; k < 3000; k++) begin
      logic [2:0]  nw;
      logic        nv;
      logic [15:0] nd;
      nw = width;
      nv = wdValid;
      nd = wdIn;
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 7))
          0, 1:    nw = 3'd1;
          2, 3:    nw = 3'd2;
          4, 5:    nw = 3'd4;
          6:       nw = 3'd3;
          default: nw = 3'($urandom_range(5, 7));
        endcase
      end
      if (!wdValid || lastRdy) begin
        nv = 1'($urandom_range(0, 1));
        nd = 16'($urandom);
      end
      applyStimulus(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, nw, nv, nd);
      step();
    end

    $display("test done: total=%0d bad=%0d", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/trace_port_tx.md
# trace_port_tx

Trace port transmitter: accepts 16-bit trace halfwords over a valid/ready handshake and serialises them LSB-first onto a 1/2/4-bit double-data-rate trace bus, emitting one rising-edge and one falling-edge slice per `clk`. It inserts the TPIU frame sync (32'h7fff_ffff) at start-up, after any width change and periodically, and pads idle slots with the 16'h7fff halfword. It sits on the stimulus side of the orbtrace bench and loopback path and drives the trace receiver's `traceDina`/`traceDinb` inputs directly.

## Interface
- `BUSWIDTH`, 4: physical trace bus width; must be ≥ 4 to support all widths.
- `SYNC_INTERVAL`, 4096: halfwords between periodic syncs (1..65535).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `width`  in  3  active bus width; 1, 2 or 4 valid, all other values invalid.
- `WdIn`  in  16  halfword to transmit.
- `WdValid`  in  1  `WdIn` is valid.
- `WdReady`  out  1  block takes `WdIn` this cycle when `WdValid` is also high.
- `traceDouta`  out  BUSWIDTH  rising-edge slice.
- `traceDoutb`  out  BUSWIDTH  falling-edge slice.
- `syncTx`  out  1  one-cycle pulse in the cycle a sync unit is loaded.

## Operation
- Unit: one 32-bit sync or one 16-bit halfword (data or fill), sent LSB first. Each cycle drives `traceDouta[w-1:0]` = next w bits and `traceDoutb[w-1:0]` = the w bits after them, with w = latched width. Bits above w are 0.
- Slices per unit are 32/(2w) for sync and 16/(2w) for a halfword. For w=4 this is 4 and 2 cycles; for w=2, 8 and 4; for w=1, 16 and 8.
- A `remaining` counter holds the slices still to drive. A load cycle is any cycle with `remaining`==0.
- In a load cycle the block latches `width` and loads the next unit. The priority order is:
  1. `width` invalid: drive zeros, set `WdReady`=0, set state IDLE_INV, clear the sync counter, and force a sync.
  2. Sync is due: this covers post-reset, width differing from the latched width, leaving IDLE_INV, or the interval count reaching `SYNC_INTERVAL`. Load 32'h7fff_ffff, pulse `syncTx`, and clear the interval count.
  3. `WdValid`: load `WdIn` and increment the interval count.
  4. Otherwise: load 16'h7fff and increment the interval count.
- `WdReady` is combinational. It is 1 only in a load cycle with a valid `width` and no sync due.
- States: SYNC, DATA, IDLE_INV. Transitions are evaluated only in load cycles.
- A data word equal to 16'h7fff is sent verbatim, and the receiver discards it. Producers must not rely on it.

## Timing
- Reset values: `traceDouta`=0, `traceDoutb`=0, `WdReady`=0, `syncTx`=0, `remaining`=0, sync pending.
- The first cycle after reset is a load cycle that loads sync. Slice 0 appears after that edge.
- Load and first slice happen on the same edge. A word accepted at edge N drives its bits [2w-1:0] after edge N.
- Streaming has no gaps. With `WdValid` held high, `WdReady` pulses once every 16/(2w) cycles, except across sync units.
- `width` is ignored between load cycles. A change mid-unit takes effect at the next load cycle and is preceded by a sync.
- Reset mid-unit abandons the unit immediately. There is no partial flush.
- If the interval and a width change coincide, only one sync is sent.

## Configuration
- `TRACE_PORT_TX_SYNC_REQ_EN` defined:
  - Adds input `syncReq` (1 bit), which is sticky-captured.
  - A pending request forces a sync at the next load cycle with valid width, then clears.
  - A request arriving during a load cycle that is already sending sync is merged into that sync.
- Undefined: the `syncReq` port is absent and only the automatic syncs occur.

## Structure
- The shared package holds:
  - state enum {SYNC, DATA, IDLE_INV}
  - `TPIU_SYNC` = 32'h7fff_ffff
  - `TPIU_FILL` = 16'h7fff
  - the width-valid function
  - the slices-per-unit function
- One sub-module, `trace_port_tx_shifter`, owns the 32-bit shift register, width-dependent slicing and the `remaining` counter. The top level owns the handshake, priority and sync interval.

## Test plan
- Reset release, w=4, `WdValid`=0 → slices (a,b) are (f,f),(f,f),(f,f),(f,7), then (f,f),(f,7) repeating as fill. `syncTx` pulses once in the first load cycle.
- w=4, stream 0x1234 then 0x5678 → after sync, (4,3),(2,1),(8,7),(6,5) with no gap. `WdReady` is high on alternate cycles.
- w=1, single word 0xA5A5 → 8 cycles of `traceDouta[0]`,`traceDoutb[0]` = (1,0),(1,0),(0,1),(0,1),(1,0),(1,0),(0,1),(0,1).
- Width changes 4→2 mid-halfword → current halfword completes at w=4, then an 8-cycle sync at w=2 with `syncTx` pulsing. `WdReady` stays low during the sync.
- `SYNC_INTERVAL`=4 with a continuous stream → after every 4 accepted words, one sync unit. Loopback through the trace receiver recovers all words in order.
- `width`=3 → outputs are 0 and `WdReady`=0 indefinitely. Returning to 2 yields sync first, then data.
